mips_multicycle_control: RTL and testbench

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_multicycle_control.sv | 220 ++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: main FSM that sequences the datapath through
// fetch/decode/execute/memory/writeback steps. Outputs are decoded from the
// registered state plus the live opcode/funct/alu_zero inputs.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       rstb,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    output logic       pc_ena,
    output logic       iord,
    output logic       mem_wr_ena,
    output logic       ir_ena,
    output logic       reg_wr_ena,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [3:0] alu_control,
    output logic [1:0] pc_src,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IEXEC   = 4'd9,
        IWB     = 4'd10,
        JUMP    = 4'd11,
        ERROR   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // R-type function decode: returns {valid, alu_control}
    function automatic logic [4:0] decode_funct(input logic [5:0] f);
        logic [4:0] r;
        case (f)
            6'b100000: r = {1'b1, ALU_ADD};
            6'b100010: r = {1'b1, ALU_SUB};
            6'b100100: r = {1'b1, ALU_AND};
            6'b100101: r = {1'b1, ALU_OR};
            6'b100110: r = {1'b1, ALU_XOR};
            6'b100111: r = {1'b1, ALU_NOR};
            6'b101010: r = {1'b1, ALU_SLT};
            default:   r = {1'b0, ALU_ADD};
        endcase
        return r;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [4:0] funct_dec_s;
    logic       pc_ena_s;
    logic       mem_wr_ena_s;
    logic       ir_ena_s;
    logic       reg_wr_ena_s;

    assign funct_dec_s = decode_funct(funct);

    // State register with synchronous active-low reset back to FETCH
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-state control decode; every output defaults to idle
    always_comb begin
        state_next_s = ERROR;
        pc_ena_s     = 1'b0;
        iord         = 1'b0;
        mem_wr_ena_s = 1'b0;
        ir_ena_s     = 1'b0;
        reg_wr_ena_s = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dst      = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        imm_zext     = 1'b0;
        alu_control  = ALU_ADD;
        pc_src       = 2'b00;
        illegal_op   = 1'b0;
        case (state_r)
            FETCH: begin
                ir_ena_s     = 1'b1;
                alu_src_b    = 2'b01;
                pc_ena_s     = 1'b1;
                state_next_s = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:             state_next_s = MEMADR;
                    OP_RTYPE:                 state_next_s = EXECUTE;
                    OP_BEQ, OP_BNE:           state_next_s = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_next_s = IEXEC;
                    OP_J:                     state_next_s = JUMP;
                    default:                  state_next_s = ERROR;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LW:   state_next_s = MEMRD;
                    OP_SW:   state_next_s = MEMWR;
                    default: state_next_s = ERROR;
                endcase
            end
            MEMRD: begin
                iord         = 1'b1;
                state_next_s = MEMWB;
            end
            MEMWB: begin
                reg_wr_ena_s = 1'b1;
                mem_to_reg   = 1'b1;
                state_next_s = FETCH;
            end
            MEMWR: begin
                iord         = 1'b1;
                mem_wr_ena_s = 1'b1;
                state_next_s = FETCH;
            end
            EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_dec_s[3:0];
                if (funct_dec_s[4]) begin
                    state_next_s = ALUWB;
                end else begin
                    state_next_s = ERROR;
                end
            end
            ALUWB: begin
                reg_wr_ena_s = 1'b1;
                reg_dst      = 1'b1;
                state_next_s = FETCH;
            end
            BRANCH: begin
                alu_src_a    = 1'b1;
                alu_control  = ALU_SUB;
                pc_src       = 2'b01;
                state_next_s = FETCH;
                case (opcode)
                    OP_BEQ:  pc_ena_s = alu_zero;
                    OP_BNE:  pc_ena_s = ~alu_zero;
                    default: pc_ena_s = 1'b0;
                endcase
            end
            IEXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                state_next_s = IWB;
                case (opcode)
                    OP_ANDI: begin
                        alu_control = ALU_AND;
                        imm_zext    = 1'b1;
                    end
                    OP_ORI: begin
                        alu_control = ALU_OR;
                        imm_zext    = 1'b1;
                    end
                    default: begin
                        alu_control = ALU_ADD;
                        imm_zext    = 1'b0;
                    end
                endcase
            end
            IWB: begin
                reg_wr_ena_s = 1'b1;
                state_next_s = FETCH;
            end
            JUMP: begin
                pc_src       = 2'b10;
                pc_ena_s     = 1'b1;
                state_next_s = FETCH;
            end
            ERROR: begin
                illegal_op   = 1'b1;
                state_next_s = ERROR;
            end
            default: begin
                state_next_s = ERROR;
            end
        endcase
    end

    // Architectural write enables are suppressed while reset is held low
    assign pc_ena     = pc_ena_s     & rstb;
    assign ir_ena     = ir_ena_s     & rstb;
    assign mem_wr_ena = mem_wr_ena_s & rstb;
    assign reg_wr_ena = reg_wr_ena_s & rstb;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed testbench for mips_multicycle_control: walks each instruction
// class cycle by cycle and compares the full control word to hand-built
// per-state constants.
module tb_mips_multicycle_control;

    logic       clk;
    logic       rstb;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       pc_ena, iord, mem_wr_ena, ir_ena, reg_wr_ena, mem_to_reg;
    logic       reg_dst, alu_src_a, imm_zext, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_control;

    int errors = 0;
    int checks = 0;

    mips_multicycle_control dut (
        .clk        (clk),
        .rstb       (rstb),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .pc_ena     (pc_ena),
        .iord       (iord),
        .mem_wr_ena (mem_wr_ena),
        .ir_ena     (ir_ena),
        .reg_wr_ena (reg_wr_ena),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_zext   (imm_zext),
        .alu_control(alu_control),
        .pc_src     (pc_src),
        .illegal_op (illegal_op)
    );

    // Control word order:
    // pc_ena iord mem_wr ir_ena reg_wr mem_to_reg reg_dst src_a | src_b | zext | alu_ctl | pc_src | illegal
    logic [17:0] obs;
    assign obs = {pc_ena, iord, mem_wr_ena, ir_ena, reg_wr_ena, mem_to_reg, reg_dst, alu_src_a,
                  alu_src_b, imm_zext, alu_control, pc_src, illegal_op};

    localparam logic [17:0] V_FETCH      = {8'b10010000, 2'b01, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_FETCH_RST  = {8'b00000000, 2'b01, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_DECODE     = {8'b00000000, 2'b11, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_MEMADR     = {8'b00000001, 2'b10, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_MEMRD      = {8'b01000000, 2'b00, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_MEMWB      = {8'b00001100, 2'b00, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_MEMWR      = {8'b01100000, 2'b00, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_MEMWR_RST  = {8'b01000000, 2'b00, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_EXEC_BAD   = {8'b00000001, 2'b00, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_ALUWB      = {8'b00001010, 2'b00, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_BR_TAKEN   = {8'b10000001, 2'b00, 1'b0, 4'b0110, 2'b01, 1'b0};
    localparam logic [17:0] V_BR_NOT     = {8'b00000001, 2'b00, 1'b0, 4'b0110, 2'b01, 1'b0};
    localparam logic [17:0] V_IEXEC_ORI  = {8'b00000001, 2'b10, 1'b1, 4'b0001, 2'b00, 1'b0};
    localparam logic [17:0] V_IEXEC_ANDI = {8'b00000001, 2'b10, 1'b1, 4'b0000, 2'b00, 1'b0};
    localparam logic [17:0] V_IEXEC_ADDI = {8'b00000001, 2'b10, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_IWB        = {8'b00001000, 2'b00, 1'b0, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] V_JUMP       = {8'b10000000, 2'b00, 1'b0, 4'b0010, 2'b10, 1'b0};
    localparam logic [17:0] V_ERROR      = {8'b00000000, 2'b00, 1'b0, 4'b0010, 2'b00, 1'b1};

    // R-type functs and their expected ALU codes
    logic [5:0] fn_tab  [7] = '{6'b100010, 6'b100000, 6'b100100, 6'b100101,
                                6'b100110, 6'b100111, 6'b101010};
    logic [3:0] ctl_tab [7] = '{4'b0110, 4'b0010, 4'b0000, 4'b0001,
                                4'b0011, 4'b1100, 4'b0111};

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rstb     = 1'b0;
        opcode   = 6'b100011;
        funct    = 6'b000000;
        alu_zero = 1'b0;

        // Reset: FETCH with write enables forced low
        tick();
        check("reset_fetch", V_FETCH_RST);
        tick();
        check("reset_hold", V_FETCH_RST);
        rstb = 1'b1;
        #1;
        check("first_fetch", V_FETCH);

        // lw: 5 cycles
        tick(); check("lw_decode", V_DECODE);
        tick(); check("lw_memadr", V_MEMADR);
        tick(); check("lw_memrd",  V_MEMRD);
        tick(); check("lw_memwb",  V_MEMWB);
        tick(); check("lw_fetch",  V_FETCH);

        // R-type: every decoded funct, 4 cycles each
        opcode = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            funct = fn_tab[i];
            tick(); check("r_decode", V_DECODE);
            tick(); check("r_execute", {8'b00000001, 2'b00, 1'b0, ctl_tab[i], 2'b00, 1'b0});
            tick(); check("r_aluwb", V_ALUWB);
            tick(); check("r_fetch", V_FETCH);
        end

        // bne with alu_zero=1: not taken
        opcode = 6'b000101; alu_zero = 1'b1;
        tick(); check("bne_decode", V_DECODE);
        tick(); check("bne_z1", V_BR_NOT);
        alu_zero = 1'b0;
        #1;
        check("bne_z0_comb", V_BR_TAKEN);
        tick(); check("bne_fetch", V_FETCH);

        // bne with alu_zero=0: taken
        tick(); check("bne2_decode", V_DECODE);
        tick(); check("bne_z0", V_BR_TAKEN);
        tick(); check("bne2_fetch", V_FETCH);

        // beq with alu_zero=1: taken; with 0: not taken
        opcode = 6'b000100; alu_zero = 1'b1;
        tick(); check("beq_decode", V_DECODE);
        tick(); check("beq_z1", V_BR_TAKEN);
        alu_zero = 1'b0;
        #1;
        check("beq_z0", V_BR_NOT);
        tick(); check("beq_fetch", V_FETCH);

        // ori / andi / addi: 4 cycles
        opcode = 6'b001101;
        tick(); check("ori_decode", V_DECODE);
        tick(); check("ori_iexec", V_IEXEC_ORI);
        tick(); check("ori_iwb", V_IWB);
        tick(); check("ori_fetch", V_FETCH);
        opcode = 6'b001100;
        tick(); tick(); check("andi_iexec", V_IEXEC_ANDI);
        tick(); check("andi_iwb", V_IWB);
        tick(); check("andi_fetch", V_FETCH);
        opcode = 6'b001000;
        tick(); tick(); check("addi_iexec", V_IEXEC_ADDI);
        tick(); check("addi_iwb", V_IWB);
        tick(); check("addi_fetch", V_FETCH);

        // j: 3 cycles
        opcode = 6'b000010;
        tick(); check("j_decode", V_DECODE);
        tick(); check("j_jump", V_JUMP);
        tick(); check("j_fetch", V_FETCH);

        // sw, reset asserted during MEMWR
        opcode = 6'b101011;
        tick(); check("sw_decode", V_DECODE);
        tick(); check("sw_memadr", V_MEMADR);
        tick(); check("sw_memwr", V_MEMWR);
        rstb = 1'b0;
        #1;
        check("sw_memwr_rst", V_MEMWR_RST);
        tick(); check("sw_rst_fetch", V_FETCH_RST);
        rstb = 1'b1;
        #1;
        check("sw_rel_fetch", V_FETCH);

        // sw completes normally after reset
        tick(); tick(); tick(); check("sw2_memwr", V_MEMWR);
        tick(); check("sw2_fetch", V_FETCH);

        // Undecoded funct: EXECUTE then ERROR, no register write
        opcode = 6'b000000; funct = 6'b000001;
        tick(); check("badfn_decode", V_DECODE);
        tick(); check("badfn_execute", V_EXEC_BAD);
        tick(); check("badfn_error", V_ERROR);
        rstb = 1'b0;
        tick(); check("badfn_rst", V_FETCH_RST);
        rstb = 1'b1;
        #1;
        check("badfn_rel", V_FETCH);

        // Illegal opcode: ERROR held for 20 cycles, cleared by reset
        opcode = 6'b111111;
        tick(); check("ill_decode", V_DECODE);
        for (int i = 0; i < 20; i++) begin
            tick(); check("ill_error_hold", V_ERROR);
        end
        rstb = 1'b0;
        #1;
        check("ill_error_rstlow", V_ERROR);
        tick(); check("ill_rst_fetch", V_FETCH_RST);
        rstb = 1'b1;
        opcode = 6'b100011;
        #1;
        check("ill_rel_fetch", V_FETCH);
        tick(); check("ill_after_decode", V_DECODE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
